// File: rtl/ntt_mem_pkg.sv
// Shared geometry and helpers for the 8-bank conflict-free polynomial layout.
// Both the forward address map and the linear reader use row_flip so they agree.
package ntt_mem_pkg;

  localparam int unsigned ROWS   = 128;
  localparam int unsigned BANKS  = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned ROW_W  = 7;
  localparam int unsigned BANK_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    STREAM
  } state_t;

  // Odd-parity rows store their coefficients in reversed bank order.
  function automatic logic row_flip(input logic [ROW_W-1:0] row);
    return ^row;
  endfunction

endpackage

// File: rtl/bank_to_linear_reader_permute.sv
// Conditional-reverse mux: maps the 8 bank words of one row to natural slot order.
module bank_permute
  import ntt_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 256
) (
  input  logic                    flip,
  input  logic [BANKS*DATA_W-1:0] bank_words,
  output logic [BANKS*DATA_W-1:0] slot_words
);

  always_comb begin
    slot_words = '0;
    for (int unsigned s = 0; s < BANKS; s++) begin
      if (flip) begin
        slot_words[s*DATA_W +: DATA_W] = bank_words[(BANKS-1-s)*DATA_W +: DATA_W];
      end else begin
        slot_words[s*DATA_W +: DATA_W] = bank_words[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/bank_to_linear_reader.sv
// Drains a 128x8 banked polynomial and streams coefficients 0..1023 in natural
// order over valid/ready, un-permuting each row through bank_permute.
module bank_to_linear_reader
  import ntt_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [6:0]        rd_row,
  input  logic [DATA_W-1:0] rd_data_0,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  input  logic [DATA_W-1:0] rd_data_3,
  input  logic [DATA_W-1:0] rd_data_4,
  input  logic [DATA_W-1:0] rd_data_5,
  input  logic [DATA_W-1:0] rd_data_6,
  input  logic [DATA_W-1:0] rd_data_7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [9:0]        out_index,
  output logic              out_last
);

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [BANK_W-1:0]       slot;
  logic [DATA_W-1:0]       buffer [BANKS];
  logic [BANKS*DATA_W-1:0] bank_words;
  logic [BANKS*DATA_W-1:0] slot_words;
  logic                    flip;
  logic                    accept;
  logic                    last_slot;
  logic                    last_row;
  logic                    row_advance;

  assign bank_words = {rd_data_7, rd_data_6, rd_data_5, rd_data_4,
                       rd_data_3, rd_data_2, rd_data_1, rd_data_0};
  assign flip = row_flip(row);

  bank_permute #(.DATA_W(DATA_W)) u_permute (
    .flip      (flip),
    .bank_words(bank_words),
    .slot_words(slot_words)
  );

  // The next row is fetched in the same cycle slot 7 is accepted, so the bank
  // data lands during LOAD and only one bubble cycle is spent per row.
  always_comb begin
    accept      = (state == STREAM) && out_ready;
    last_slot   = (slot == BANK_W'(BANKS - 1));
    last_row    = (row == ROW_W'(ROWS - 1));
    row_advance = accept && last_slot && !last_row;
    rd_en       = (state == FETCH) || row_advance;
    rd_row      = '0;
    if (row_advance) begin
      rd_row = row + ROW_W'(1);
    end else if (state == FETCH) begin
      rd_row = row;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == STREAM);
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (state == STREAM) begin
      out_data  = buffer[slot];
      out_index = {row, slot};
      out_last  = last_slot && last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      slot  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            row   <= '0;
            slot  <= '0;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          state <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (!last_slot) begin
              slot <= slot + BANK_W'(1);
            end else if (!last_row) begin
              row   <= row + ROW_W'(1);
              slot  <= '0;
              state <= LOAD;
            end else begin
              row   <= '0;
              slot  <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Row buffer carries no reset; its contents are never observed outside STREAM.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int unsigned s = 0; s < BANKS; s++) begin
        buffer[s] <= slot_words[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_bank_to_linear_reader.sv
// Randomized bench for bank_to_linear_reader: banked memory model, stream
// collector, and a reference model built from the address-map rules.
module tb_bank_to_linear_reader;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [6:0]    rd_row;
  logic [DW-1:0] rdd [8];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [9:0]    out_index;
  logic          out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [DW-1:0] mem [8][128];

  int            q_idx  [$];
  logic [DW-1:0] q_data [$];
  bit            q_last [$];
  int            q_cyc  [$];
  int rd_cnt, rd_bad, rd_order_bad, next_rd_row, stab_bad, hold5;
  int done_cyc, done_cnt, timed_out, stop_cyc;

  bank_to_linear_reader #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_data_0(rdd[0]),
    .rd_data_1(rdd[1]),
    .rd_data_2(rdd[2]),
    .rd_data_3(rdd[3]),
    .rd_data_4(rdd[4]),
    .rd_data_5(rdd[5]),
    .rd_data_6(rdd[6]),
    .rd_data_7(rdd[7]),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank memories: 1-cycle read latency; junk when not read.
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (rd_en) rdd[b] <= mem[b][rd_row];
      else       rdd[b] <= {(DW/16){16'hDEAD}};
    end
  end

  // Coefficient i lives at row i/8; odd-parity rows hold slots in reversed bank order.
  function automatic logic [DW-1:0] model(input int i);
    int r, s, b;
    r = i / 8;
    s = i % 8;
    b = ($countones(r) % 2 == 1) ? 7 - s : s;
    return mem[b][r];
  endfunction

  function automatic int model_errs(output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < 1024; i++) begin
      if (q_idx[i] != i || q_data[i] !== model(i) || q_last[i] !== (i == 1023)) begin
        n++;
        if (first < 0) first = i;
      end
    end
    return n;
  endfunction

  task automatic fill_identity;
    for (int r = 0; r < 128; r++)
      for (int b = 0; b < 8; b++)
        mem[b][r] = DW'(r * 8 + (($countones(r) % 2 == 1) ? 7 - b : b));
  endtask

  task automatic fill_random;
    for (int r = 0; r < 128; r++)
      for (int b = 0; b < 8; b++)
        mem[b][r] = {$urandom, $urandom};
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 4 at index 5 and once per
  // slot 7; 3: random ready with start re-pulsed while busy.
  task automatic collect(input int mode, input int stop_idx, input int budget);
    bit            prev_stall = 0;
    logic [9:0]    p_idx = '0;
    logic [DW-1:0] p_data = '0;
    logic          p_last = 1'b0;
    int            c;
    int            hold5_req = 0;
    int            stall7_row = -1;
    q_idx.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
    rd_cnt = 0; rd_bad = 0; rd_order_bad = 0; next_rd_row = 0; stab_bad = 0;
    hold5 = 0; done_cyc = -1; done_cnt = 0; timed_out = 0; stop_cyc = -1;
    for (int n = 0; n < budget; n++) begin
      c = cyc - t0;
      out_ready = 1'b1;
      if (mode == 1 || mode == 3) out_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2) begin
        if (out_valid && out_index == 10'd5 && hold5_req < 4) begin
          out_ready = 1'b0;
          hold5_req++;
        end else if (out_valid && out_index[2:0] == 3'd7 && int'(out_index[9:3]) != stall7_row) begin
          out_ready = 1'b0;
          stall7_row = int'(out_index[9:3]);
        end
      end
      if (mode == 3) start = (c == 50 || c == 400);
      #1;
      if (prev_stall && !(out_valid && out_index == p_idx && out_data == p_data && out_last == p_last))
        stab_bad++;
      if (out_valid && out_index == 10'd5 && !out_ready) hold5++;
      if (rd_en) begin
        rd_cnt++;
        if (int'(rd_row) != next_rd_row) rd_order_bad++;
        next_rd_row++;
        if (out_valid && !(out_ready && out_index[2:0] == 3'd7)) rd_bad++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (out_valid && out_ready) begin
        q_idx.push_back(int'(out_index));
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_cyc.push_back(c);
      end
      prev_stall = out_valid && !out_ready;
      p_idx = out_index; p_data = out_data; p_last = out_last;
      if (done || (out_valid && int'(out_index) == stop_idx)) begin
        stop_cyc = c;
        start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    timed_out = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, done, rd_en, out_valid, out_last} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, rd_en, out_valid, out_last});
    end
    total++;
    if (rd_row !== 7'd0 || out_index !== 10'd0 || out_data !== '0) begin
      bad++; $display("FAIL reset_buses: got row=%0d idx=%0d data=%0h want 0", rd_row, out_index, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_unload;
    int first, errs, cerr;
    fill_identity();
    pulse_start();
    collect(0, -1, 2000);
    total++;
    if (timed_out != 0 || q_idx.size() != 1024) begin
      bad++; $display("FAIL full_count: got %0d words timeout=%0d want 1024", q_idx.size(), timed_out);
      return;
    end
    errs = model_errs(first);
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL full_data: %0d errors first at %0d got idx=%0d data=%0h want %0h",
                      errs, first, q_idx[first], q_data[first], DW'(first));
    end
    cerr = 0;
    for (int r = 0; r < 128; r++) if (q_cyc[8 * r] != 3 + 9 * r) cerr++;
    total++;
    if (cerr != 0 || q_cyc[0] != 3) begin
      bad++; $display("FAIL row_timing: got %0d bad rows first word cyc %0d want 0 bad, cyc 3", cerr, q_cyc[0]);
    end
    total++;
    if (q_cyc[1023] != 1153 || q_last[1023] !== 1'b1) begin
      bad++; $display("FAIL last_cycle: got %0d want 1153", q_cyc[1023]);
    end
    total++;
    if (done_cyc != 1154 || done_cnt != 1) begin
      bad++; $display("FAIL done_cycle: got %0d (count %0d) want 1154 (1)", done_cyc, done_cnt);
    end
    total++;
    if (rd_cnt != 128 || rd_order_bad != 0 || rd_bad != 0) begin
      bad++; $display("FAIL rd_strobes: got %0d order_bad=%0d bad=%0d want 128 0 0", rd_cnt, rd_order_bad, rd_bad);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_after: got %b want 0", busy);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_permutation;
    fill_random();
    for (int b = 0; b < 8; b++) begin
      mem[b][0] = DW'(8'hA0 + b);
      mem[b][1] = DW'(8'hB0 + b);
    end
    pulse_start();
    collect(0, -1, 2000);
    total++;
    if (q_idx.size() < 16) begin
      bad++; $display("FAIL perm_count: got %0d words want 1024", q_idx.size());
      return;
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (q_data[i] !== DW'(8'hA0 + i)) begin
        bad++; $display("FAIL perm_row0[%0d]: got %0h want %0h", i, q_data[i], 8'hA0 + i);
      end
    end
    total++;
    if (q_data[8] !== DW'(8'hB7) || q_data[15] !== DW'(8'hB0)) begin
      bad++; $display("FAIL perm_row1: got %0h/%0h want b7/b0", q_data[8], q_data[15]);
    end
  endtask

  task automatic test_backpressure;
    int first, errs;
    fill_random();
    pulse_start();
    collect(2, -1, 3000);
    total++;
    if (timed_out != 0 || q_idx.size() != 1024) begin
      bad++; $display("FAIL bp_count: got %0d words timeout=%0d want 1024", q_idx.size(), timed_out);
      return;
    end
    errs = model_errs(first);
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL bp_data: %0d errors first at %0d got %0h want %0h", errs, first, q_data[first], model(first));
    end
    total++;
    if (hold5 != 4 || stab_bad != 0) begin
      bad++; $display("FAIL bp_hold: got hold5=%0d unstable=%0d want 4 0", hold5, stab_bad);
    end
    total++;
    if (rd_cnt != 128 || rd_bad != 0 || rd_order_bad != 0) begin
      bad++; $display("FAIL bp_rd_en: got %0d bad=%0d order=%0d want 128 0 0", rd_cnt, rd_bad, rd_order_bad);
    end
  endtask

  task automatic test_random_ready(input int mode, input string tag);
    int first, errs;
    fill_random();
    pulse_start();
    collect(mode, -1, 6000);
    total++;
    if (timed_out != 0 || q_idx.size() != 1024) begin
      bad++; $display("FAIL %s_count: got %0d words timeout=%0d want 1024", tag, q_idx.size(), timed_out);
      return;
    end
    errs = model_errs(first);
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL %s_data: %0d errors first at %0d got %0h want %0h", tag, errs, first, q_data[first], model(first));
    end
    total++;
    if (stab_bad != 0 || rd_cnt != 128 || rd_bad != 0 || done_cnt != 1) begin
      bad++; $display("FAIL %s_ctrl: got unstable=%0d rd=%0d rd_bad=%0d done=%0d want 0 128 0 1",
                      tag, stab_bad, rd_cnt, rd_bad, done_cnt);
    end
  endtask

  task automatic test_reset_mid_stream;
    fill_random();
    pulse_start();
    collect(1, 300, 3000);
    total++;
    if (timed_out != 0) begin
      bad++; $display("FAIL mid_reach300: got timeout want index 300");
    end
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({busy, done, rd_en, out_valid, out_last} !== 5'b0 || rd_row !== 7'd0 ||
        out_index !== 10'd0 || out_data !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got flags=%b row=%0d idx=%0d data=%0h want all 0",
                      {busy, done, rd_en, out_valid, out_last}, rd_row, out_index, out_data);
    end
    rst = 1'b0;
    pulse_start();
    collect(0, 0, 20);
    total++;
    if (timed_out != 0 || stop_cyc != 3 || q_idx.size() != 1 || q_data[0] !== model(0)) begin
      bad++; $display("FAIL restart_first: got cyc=%0d words=%0d want cyc 3 index 0", stop_cyc, q_idx.size());
    end
  endtask

  task automatic test_start_with_rst;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL start_rst_same: got busy=%b rd_en=%b valid=%b want 0 0 0", busy, rd_en, out_valid);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      bad++; $display("FAIL start_rst_after: got busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    test_reset();
    test_full_unload();
    test_permutation();
    test_backpressure();
    test_random_ready(1, "rand_ready");
    test_random_ready(3, "restart_busy");
    test_reset_mid_stream();
    test_start_with_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
